// File: rtl/mem_access_sequencer.sv
// Sequences two 16-bit requesters onto the byte-wide memory_interface register port.
// Optional macro MEM_SEQ_ROUND_ROBIN_EN alternates grants under contention (default: requester 0 wins).
module mem_access_sequencer #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int BUSY_BIT    = 0
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        req0,
    input  logic        we0,
    input  logic [22:0] addr0,
    input  logic [15:0] wdata0,
    output logic        ack0,
    input  logic        req1,
    input  logic        we1,
    input  logic [22:0] addr1,
    input  logic [15:0] wdata1,
    output logic        ack1,
    output logic [15:0] rdata,
    output logic        err,
    output logic        busy,
    output logic        mi_write,
    output logic        mi_read,
    output logic [3:0]  mi_address,
    output logic [7:0]  mi_data_in,
    input  logic [7:0]  mi_data_out
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        IDLE, WA0, WA1, WA2, WD0, WD1, GO, PRQ, PCHK, RD0, RD0C, RD1, RD1C, DONE
    } state_t;

    state_t        state_q, state_d;
    logic          winner_q, winner_d;
    logic          we_q, we_d;
    logic [22:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          errPending_q, errPending_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    rdLo_q, rdLo_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          grantSel;

`ifdef MEM_SEQ_ROUND_ROBIN_EN
    // Holds the requester favoured on the next tie, i.e. the one not granted last.
    logic rrPtr_q;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rrPtr_q <= 1'b0;
        end else if (state_q == DONE) begin
            rrPtr_q <= ~winner_q;
        end
    end

    always_comb begin
        if (req0 && req1) begin
            grantSel = rrPtr_q;
        end else begin
            grantSel = req1 && !req0;
        end
    end
`else
    always_comb begin
        grantSel = !req0;
    end
`endif

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q      <= IDLE;
            winner_q     <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            errPending_q <= 1'b0;
            cnt_q        <= '0;
            rdLo_q       <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            errPending_q <= errPending_d;
            cnt_q        <= cnt_d;
            rdLo_q       <= rdLo_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        errPending_d = errPending_q;
        cnt_d        = cnt_q;
        rdLo_d       = rdLo_q;
        rdata_d      = rdata_q;
        mi_write     = 1'b0;
        mi_read      = 1'b0;
        mi_address   = 4'h0;
        mi_data_in   = 8'h00;
        ack0         = 1'b0;
        ack1         = 1'b0;
        err          = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    winner_d     = grantSel;
                    we_d         = grantSel ? we1 : we0;
                    addr_d       = grantSel ? addr1 : addr0;
                    wdata_d      = grantSel ? wdata1 : wdata0;
                    errPending_d = 1'b0;
                    state_d      = WA0;
                end
            end
            WA0: begin
                mi_write   = 1'b1;
                mi_address = 4'h1;
                mi_data_in = addr_q[7:0];
                state_d    = WA1;
            end
            WA1: begin
                mi_write   = 1'b1;
                mi_address = 4'h2;
                mi_data_in = addr_q[15:8];
                state_d    = WA2;
            end
            WA2: begin
                mi_write   = 1'b1;
                mi_address = 4'h3;
                mi_data_in = {1'b0, addr_q[22:16]};
                state_d    = we_q ? WD0 : GO;
            end
            WD0: begin
                mi_write   = 1'b1;
                mi_address = 4'h4;
                mi_data_in = wdata_q[7:0];
                state_d    = WD1;
            end
            WD1: begin
                mi_write   = 1'b1;
                mi_address = 4'h5;
                mi_data_in = wdata_q[15:8];
                state_d    = GO;
            end
            GO: begin
                mi_write   = 1'b1;
                mi_address = we_q ? 4'h8 : 4'h9;
                cnt_d      = '0;
                state_d    = PRQ;
            end
            PRQ: begin
                mi_read    = 1'b1;
                mi_address = 4'hA;
                state_d    = PCHK;
            end
            // A timed-out read reports zero data rather than stale bytes.
            PCHK: begin
                if (mi_data_out[BUSY_BIT]) begin
                    if (cnt_q == TMAX) begin
                        errPending_d = 1'b1;
                        state_d      = DONE;
                        if (!we_q) begin
                            rdata_d = 16'h0000;
                        end
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = PRQ;
                    end
                end else begin
                    state_d = we_q ? DONE : RD0;
                end
            end
            RD0: begin
                mi_read    = 1'b1;
                mi_address = 4'h6;
                state_d    = RD0C;
            end
            RD0C: begin
                rdLo_d  = mi_data_out;
                state_d = RD1;
            end
            RD1: begin
                mi_read    = 1'b1;
                mi_address = 4'h7;
                state_d    = RD1C;
            end
            RD1C: begin
                rdata_d = {mi_data_out, rdLo_q};
                state_d = DONE;
            end
            DONE: begin
                ack0    = ~winner_q;
                ack1    = winner_q;
                err     = errPending_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rdata = rdata_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Shares the byte-wide memory_interface register port between two 16-bit requesters. Requester 0 is the PicoBlaze-side bus. Requester 1 is the UART/DMA-side bus.
- For each granted request it issues the full register sequence into memory_interface: address bytes, data bytes, start command, status polling, and read-data fetch.
- Returns a single ack pulse to the requester, with read data and an error flag.
- Sits between the port-decode logic and memory_interface in soc_block.

Parameters:
- TIMEOUT_CYC, 1024: cycles allowed in status polling before the transaction is aborted with an error.
- BUSY_BIT, 0: bit of memory_interface status register (reg 4'hA) that reads 1 while a memory cycle is in progress.

Ports:
- clk  in  1  system clock.
- resetb  in  1  asynchronous active-low reset.
- req0  in  1  requester 0 request; held until ack0.
- we0  in  1  requester 0: 1 = write, 0 = read.
- addr0  in  23  requester 0 word address.
- wdata0  in  16  requester 0 write data.
- ack0  out  1  one-cycle completion pulse to requester 0.
- req1, we1, addr1, wdata1, ack1: same as above, for requester 1.
- rdata  out  16  read data of the last completed read; valid with ack, held until the next read completes.
- err  out  1  pulses with ack when the transaction timed out.
- busy  out  1  high while any transaction is in progress (state != IDLE).
- mi_write  out  1  one-cycle register write strobe to memory_interface.
- mi_read  out  1  one-cycle register read strobe to memory_interface.
- mi_address  out  4  memory_interface register select.
- mi_data_in  out  8  register write data.
- mi_data_out  in  8  register read data; valid the cycle after mi_read.

Behaviour:
- Reset: resetb low asynchronously forces state IDLE and clears all outputs to 0, including rdata, the latched request, the grant pointer and the timeout counter.
- Reset mid-transaction: the transaction is abandoned. No ack is issued, and no further mi_* strobes occur after resetb rises until a new req arrives.
- mi_write and mi_read are never high together. mi_address and mi_data_in are 0 whenever both strobes are low.
- IDLE: if any req is high, select a winner (arbitration rules below), latch we/addr/wdata, and go to WA0. A request arriving in the same cycle that busy falls is sampled that cycle.
- Address phase: WA0, WA1, WA2 each pulse mi_write for one cycle.
  - WA0: reg 4'h1 ← addr[7:0].
  - WA1: reg 4'h2 ← addr[15:8].
  - WA2: reg 4'h3 ← {1'b0, addr[22:16]}.
- Write data phase (writes only):
  - WD0: reg 4'h4 ← wdata[7:0].
  - WD1: reg 4'h5 ← wdata[15:8].
  - Reads skip WD0 and WD1.
- GO: mi_write to reg 4'h8 (start write) or reg 4'h9 (start read), data 8'h00. The timeout counter clears here.
- Status polling:
  - PRQ: mi_read on reg 4'hA.
  - PCHK: sample mi_data_out[BUSY_BIT].
  - If busy and counter < TIMEOUT_CYC-1, increment and return to PRQ. At TIMEOUT_CYC-1, set err_pending and go to DONE.
  - If not busy: write goes to DONE, read goes to RD0.
- Read fetch:
  - RD0: mi_read on reg 4'h6. RD0C: capture low byte.
  - RD1: mi_read on reg 4'h7. RD1C: capture high byte.
  - Then DONE.
- DONE: pulse the winner's ack; err = err_pending. On a read, rdata updates in the same cycle. A timed-out read sets rdata to 16'h0000. Return to IDLE.
- Minimum latency from the IDLE sampling cycle to ack: write 9 cycles, read 11 cycles, assuming the first poll reads not-busy.
- If req drops before ack, the transaction still completes and ack still pulses. The requester ignores it.
- The losing requester's req stays pending. It is serviced on the next IDLE, and its inputs are sampled then, not at its first assertion.
- Arbitration with both req high in IDLE: requester 0 wins (fixed priority), unless modified by the optional feature below.

Optional Feature:
- Macro: MEM_SEQ_ROUND_ROBIN_EN.
- Defined: a 1-bit last-grant pointer, reset 0, selects the winner when both requests are simultaneous. The requester not granted last wins. The pointer updates at DONE.
- Undefined: fixed priority, requester 0 always wins. The pointer is not implemented.

Test Plan:
- Write: req0, we0=1, addr0=23'h12_3456, wdata0=16'hBEEF, status not busy.
  → mi_write sequence (1,56),(2,34),(3,12),(4,EF),(5,BE),(8,00), then mi_read on reg A.
  → ack0 at cycle 9, err=0.
- Read: req1, we1=0, addr1=23'h00_0010, status busy for 3 polls, regs 6/7 return A5/5A.
  → no WD writes, GO on reg 9, 4 PRQ strobes.
  → ack1 with rdata=16'h5AA5.
- Timeout: TIMEOUT_CYC=8, status stuck busy.
  → exactly 8 PRQ strobes, then ack with err=1, rdata=0000 for a read.
- Contention: req0 and req1 high together, held.
  → without macro: serviced 0, 0, 0, ...
  → with MEM_SEQ_ROUND_ROBIN_EN: 0, 1, 0, 1.
- Reset: resetb low during WD0.
  → all outputs 0 immediately; after release with no req, zero mi_* strobes for 20 cycles.
- Early drop: req0 deasserted after WA1.
  → sequence completes and ack0 still pulses once.
